// File: rtl/sr_pkg.sv
// Shared types and helpers for the set/reset flip-flop bank.
package sr_pkg;

  typedef logic [1:0] sr_mode_t;

  localparam sr_mode_t SR_HOLD    = 2'd0;
  localparam sr_mode_t SR_SET_DOM = 2'd1;
  localparam sr_mode_t SR_RST_DOM = 2'd2;
  localparam sr_mode_t SR_TOGGLE  = 2'd3;

  localparam int MAX_WIDTH = 32;
  localparam int PC_W      = 6;

  function automatic logic [PC_W-1:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < MAX_WIDTH; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/sr_flop_bank_if.sv
// Strobe/status bundle between a controller and the SR flop bank.
interface sr_flop_bank_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic             en;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] r;
  logic             conflict_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] q_rise;
  logic [WIDTH-1:0] conflict;
  logic [CNT_W-1:0] conflict_cnt;

  modport master (
    output en, s, r, conflict_clr,
    input  q, q_n, q_rise, conflict, conflict_cnt
  );

  modport slave (
    input  en, s, r, conflict_clr,
    output q, q_n, q_rise, conflict, conflict_cnt
  );
endinterface

// File: rtl/sr_cell.sv
// One synchronous SR channel with true/complement state and a rising-edge pulse.
module sr_cell
  import sr_pkg::*;
#(
  parameter sr_mode_t MODE = SR_HOLD
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic init_val,
  output logic q,
  output logic q_n,
  output logic q_rise,
  output logic evt
);

  logic q_nxt;

  always_comb begin
    q_nxt = q;
    unique case ({s, r})
      2'b10:   q_nxt = 1'b1;
      2'b01:   q_nxt = 1'b0;
      2'b11: begin
        unique case (MODE)
          SR_SET_DOM: q_nxt = 1'b1;
          SR_RST_DOM: q_nxt = 1'b0;
          SR_TOGGLE:  q_nxt = ~q;
          default:    q_nxt = q;
        endcase
      end
      default: q_nxt = q;
    endcase
  end

  assign evt = en & s & r;

  // q_n is its own flop so the complement never passes through an output inverter.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= init_val;
      q_n    <= ~init_val;
      q_rise <= 1'b0;
    end else if (en) begin
      q      <= q_nxt;
      q_n    <= ~q_nxt;
      q_rise <= q_nxt & ~q;
    end else begin
      q_rise <= 1'b0;
    end
  end

endmodule

// File: rtl/sr_flop_bank.sv
// Bank of WIDTH SR channels with sticky conflict flags and a saturating conflict counter.
module sr_flop_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] INIT          = '0,
  parameter int               CNT_W         = 8
) (
  input  logic            clk,
  input  logic            rst,
  sr_flop_bank_if.slave   bus
);

  // Sum must hold a saturated count plus a full-bank popcount without wrapping.
  localparam int SUM_W = (CNT_W + 1 > PC_W + 1) ? CNT_W + 1 : PC_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] q_w, q_n_w, q_rise_w, evt;
  logic [WIDTH-1:0] conflict_r;
  logic [CNT_W-1:0] cnt_r, cnt_nxt;
  logic [PC_W-1:0]  pc;
  logic [SUM_W-1:0] base, sum;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sr_cell #(
      .MODE (sr_mode_t'(CONFLICT_MODE))
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .en       (bus.en),
      .s        (bus.s[i]),
      .r        (bus.r[i]),
      .init_val (INIT[i]),
      .q        (q_w[i]),
      .q_n      (q_n_w[i]),
      .q_rise   (q_rise_w[i]),
      .evt      (evt[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) conflict_r <= '0;
    else     conflict_r <= (conflict_r & ~{WIDTH{bus.conflict_clr}}) | evt;
  end

  always_comb begin
    pc      = popcount(MAX_WIDTH'(evt));
    base    = bus.conflict_clr ? '0 : SUM_W'(cnt_r);
    sum     = base + SUM_W'(pc);
    cnt_nxt = (sum > SUM_W'(CNT_MAX)) ? CNT_MAX : cnt_r;
    if (sum <= SUM_W'(CNT_MAX)) cnt_nxt = CNT_W'(sum);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_r <= '0;
    else     cnt_r <= cnt_nxt;
  end

  assign bus.q            = q_w;
  assign bus.q_n          = q_n_w;
  assign bus.q_rise       = q_rise_w;
  assign bus.conflict     = conflict_r;
  assign bus.conflict_cnt = cnt_r;

  a_qn_complement: assert property (@(posedge clk) disable iff (rst) q_n_w == ~q_w);

endmodule

// File: tb/tb_sr_flop_bank.sv
// Scoreboard bench: six bank instances covering the four conflict modes, a narrow counter and a nonzero INIT.
module tb_sr_flop_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       en_d  [6];
  logic [3:0] s_d   [6];
  logic [3:0] r_d   [6];
  logic       clr_d [6];

  sr_flop_bank_if #(.WIDTH(4), .CNT_W(8)) if0 ();
  sr_flop_bank_if #(.WIDTH(4), .CNT_W(8)) if1 ();
  sr_flop_bank_if #(.WIDTH(4), .CNT_W(8)) if2 ();
  sr_flop_bank_if #(.WIDTH(4), .CNT_W(8)) if3 ();
  sr_flop_bank_if #(.WIDTH(4), .CNT_W(4)) if_sat ();
  sr_flop_bank_if #(.WIDTH(4), .CNT_W(8)) if_ini ();

  assign if0.en = en_d[0];    assign if0.s = s_d[0];    assign if0.r = r_d[0];    assign if0.conflict_clr = clr_d[0];
  assign if1.en = en_d[1];    assign if1.s = s_d[1];    assign if1.r = r_d[1];    assign if1.conflict_clr = clr_d[1];
  assign if2.en = en_d[2];    assign if2.s = s_d[2];    assign if2.r = r_d[2];    assign if2.conflict_clr = clr_d[2];
  assign if3.en = en_d[3];    assign if3.s = s_d[3];    assign if3.r = r_d[3];    assign if3.conflict_clr = clr_d[3];
  assign if_sat.en = en_d[4]; assign if_sat.s = s_d[4]; assign if_sat.r = r_d[4]; assign if_sat.conflict_clr = clr_d[4];
  assign if_ini.en = en_d[5]; assign if_ini.s = s_d[5]; assign if_ini.r = r_d[5]; assign if_ini.conflict_clr = clr_d[5];

  sr_flop_bank #(.WIDTH(4), .CONFLICT_MODE(0), .INIT(4'b0000), .CNT_W(8)) u0 (.clk(clk), .rst(rst_a), .bus(if0));
  sr_flop_bank #(.WIDTH(4), .CONFLICT_MODE(1), .INIT(4'b0000), .CNT_W(8)) u1 (.clk(clk), .rst(rst_a), .bus(if1));
  sr_flop_bank #(.WIDTH(4), .CONFLICT_MODE(2), .INIT(4'b0000), .CNT_W(8)) u2 (.clk(clk), .rst(rst_a), .bus(if2));
  sr_flop_bank #(.WIDTH(4), .CONFLICT_MODE(3), .INIT(4'b0000), .CNT_W(8)) u3 (.clk(clk), .rst(rst_a), .bus(if3));
  sr_flop_bank #(.WIDTH(4), .CONFLICT_MODE(0), .INIT(4'b0000), .CNT_W(4)) u_sat (.clk(clk), .rst(rst_a), .bus(if_sat));
  sr_flop_bank #(.WIDTH(4), .CONFLICT_MODE(0), .INIT(4'b1001), .CNT_W(8)) u_ini (.clk(clk), .rst(rst_b), .bus(if_ini));

  typedef struct {
    int         id;
    string      name;
    logic [3:0] q, q_n, q_rise, conflict;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic exp_t observe(input int id);
    exp_t o;
    o.id = id; o.name = "";
    case (id)
      0: begin o.q = if0.q; o.q_n = if0.q_n; o.q_rise = if0.q_rise; o.conflict = if0.conflict; o.cnt = if0.conflict_cnt; end
      1: begin o.q = if1.q; o.q_n = if1.q_n; o.q_rise = if1.q_rise; o.conflict = if1.conflict; o.cnt = if1.conflict_cnt; end
      2: begin o.q = if2.q; o.q_n = if2.q_n; o.q_rise = if2.q_rise; o.conflict = if2.conflict; o.cnt = if2.conflict_cnt; end
      3: begin o.q = if3.q; o.q_n = if3.q_n; o.q_rise = if3.q_rise; o.conflict = if3.conflict; o.cnt = if3.conflict_cnt; end
      4: begin o.q = if_sat.q; o.q_n = if_sat.q_n; o.q_rise = if_sat.q_rise; o.conflict = if_sat.conflict; o.cnt = {4'b0, if_sat.conflict_cnt}; end
      default: begin o.q = if_ini.q; o.q_n = if_ini.q_n; o.q_rise = if_ini.q_rise; o.conflict = if_ini.conflict; o.cnt = if_ini.conflict_cnt; end
    endcase
    return o;
  endfunction

  task automatic exp_push(input int id, input string nm, input logic [3:0] q, input logic [3:0] rise,
                          input logic [3:0] conf, input logic [7:0] cnt);
    exp_t e;
    e.id = id; e.name = nm; e.q = q; e.q_n = ~q; e.q_rise = rise; e.conflict = conf; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Drive the instances selected by m for one edge; all others idle.
  task automatic cyc(input logic [5:0] m, input logic e, input logic [3:0] s, input logic [3:0] r, input logic c);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      en_d[i]  = m[i] ? e : 1'b0;
      s_d[i]   = m[i] ? s : 4'b0;
      r_d[i]   = m[i] ? r : 4'b0;
      clr_d[i] = m[i] ? c : 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t e, o;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        o = observe(e.id);
        n_cmp++;
        if (o.q !== e.q || o.q_n !== e.q_n || o.q_rise !== e.q_rise ||
            o.conflict !== e.conflict || o.cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL %s dut%0d: got q=%b qn=%b rise=%b conf=%b cnt=%0d, want q=%b qn=%b rise=%b conf=%b cnt=%0d",
                   e.name, e.id, o.q, o.q_n, o.q_rise, o.conflict, o.cnt,
                   e.q, e.q_n, e.q_rise, e.conflict, e.cnt);
        end
      end
    end
  end

  initial begin : stim
    for (int i = 0; i < 6; i++) begin
      en_d[i] = 1'b0; s_d[i] = '0; r_d[i] = '0; clr_d[i] = 1'b0;
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    cyc(6'h00, 0, 4'h0, 4'h0, 0);
    cyc(6'h00, 0, 4'h0, 4'h0, 0);
    for (int i = 0; i < 5; i++) exp_push(i, "reset", 4'b0000, 4'b0000, 4'b0000, 8'd0);
    exp_push(5, "reset_init", 4'b1001, 4'b0000, 4'b0000, 8'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Basic set / hold / reset on the hold-mode bank
    cyc(6'h01, 1, 4'b0101, 4'b0000, 0); exp_push(0, "set_0101", 4'b0101, 4'b0101, 4'b0000, 8'd0);
    cyc(6'h01, 1, 4'b0000, 4'b0000, 0); exp_push(0, "hold_rise_clears", 4'b0101, 4'b0000, 4'b0000, 8'd0);
    cyc(6'h01, 1, 4'b0000, 4'b0001, 0); exp_push(0, "reset_bit0", 4'b0100, 4'b0000, 4'b0000, 8'd0);

    // Conflict policies, all four banks start from 0011
    cyc(6'h0F, 1, 4'b0011, 4'b1100, 0); exp_push(1, "preset_0011", 4'b0011, 4'b0011, 4'b0000, 8'd0);
    cyc(6'h0F, 1, 4'b1111, 4'b1111, 0);
    exp_push(0, "mode_hold",    4'b0011, 4'b0000, 4'b1111, 8'd4);
    exp_push(1, "mode_set_dom", 4'b1111, 4'b1100, 4'b1111, 8'd4);
    exp_push(2, "mode_rst_dom", 4'b0000, 4'b0000, 4'b1111, 8'd4);
    exp_push(3, "mode_toggle",  4'b1100, 4'b1100, 4'b1111, 8'd4);

    // Enable gating on a fresh bank
    for (int k = 0; k < 3; k++) begin
      cyc(6'h10, 0, 4'b1111, 4'b1010, 0);
      exp_push(4, "en_gated", 4'b0000, 4'b0000, 4'b0000, 8'd0);
    end

    // Clear racing a new event
    cyc(6'h01, 0, 4'b0000, 4'b0000, 1); exp_push(0, "clr_only", 4'b0011, 4'b0000, 4'b0000, 8'd0);
    cyc(6'h01, 1, 4'b0011, 4'b0011, 0); exp_push(0, "cnt_2", 4'b0011, 4'b0000, 4'b0011, 8'd2);
    cyc(6'h01, 1, 4'b0011, 4'b0011, 0);
    cyc(6'h01, 1, 4'b0001, 4'b0001, 0); exp_push(0, "cnt_5", 4'b0011, 4'b0000, 4'b0011, 8'd5);
    cyc(6'h01, 1, 4'b0100, 4'b0100, 1); exp_push(0, "clr_vs_event", 4'b0011, 4'b0000, 4'b0100, 8'd1);

    // Saturation with a 4-bit counter
    cyc(6'h10, 1, 4'b1111, 4'b1111, 0); exp_push(4, "sat_4",  4'b0000, 4'b0000, 4'b1111, 8'd4);
    cyc(6'h10, 1, 4'b1111, 4'b1111, 0); exp_push(4, "sat_8",  4'b0000, 4'b0000, 4'b1111, 8'd8);
    cyc(6'h10, 1, 4'b1111, 4'b1111, 0); exp_push(4, "sat_12", 4'b0000, 4'b0000, 4'b1111, 8'd12);
    cyc(6'h10, 1, 4'b1111, 4'b1111, 0); exp_push(4, "sat_15", 4'b0000, 4'b0000, 4'b1111, 8'd15);
    cyc(6'h10, 1, 4'b1111, 4'b1111, 0); exp_push(4, "sat_hold", 4'b0000, 4'b0000, 4'b1111, 8'd15);
    cyc(6'h10, 0, 4'b0000, 4'b0000, 1); exp_push(4, "sat_clr", 4'b0000, 4'b0000, 4'b0000, 8'd0);

    // Reset mid-operation with INIT=1001
    cyc(6'h20, 1, 4'b0110, 4'b1001, 0); exp_push(5, "ini_setup_q", 4'b0110, 4'b0110, 4'b0000, 8'd0);
    cyc(6'h20, 1, 4'b1111, 4'b1111, 0);
    cyc(6'h20, 1, 4'b0111, 4'b0111, 0); exp_push(5, "ini_setup_cnt", 4'b0110, 4'b0000, 4'b1111, 8'd7);
    rst_b = 1'b1;
    cyc(6'h20, 1, 4'b1111, 4'b0000, 0); exp_push(5, "mid_reset", 4'b1001, 4'b0000, 4'b0000, 8'd0);
    rst_b = 1'b0;
    cyc(6'h00, 0, 4'h0, 4'h0, 0);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expected entries never compared, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_flop_bank.md
Name: sr_flop_bank

Overview:
- Clocked, parametrised bank of WIDTH independent set/reset flip-flops.
- Generalises the single-bit behavioural SR element to a synchronous multi-channel register.
- The S=R=1 case is resolved by a selectable conflict policy instead of being undefined.
- Adds true/complement outputs, a one-cycle rising-edge pulse per channel, and sticky per-channel conflict flags with a saturating conflict counter. It is used wherever control logic needs latched status bits with explicit set/clear strobes.

Parameters:
- WIDTH, 4, number of independent SR channels (1..32).
- CONFLICT_MODE, 0, resolution when s[i]=r[i]=1: 0=hold, 1=set-dominant, 2=reset-dominant, 3=toggle.
- INIT, 0, WIDTH-bit reset value of q.
- CNT_W, 8, width of the saturating conflict counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global update enable; when 0 all channels hold.
- s  input  WIDTH  per-channel set strobe.
- r  input  WIDTH  per-channel reset strobe.
- conflict_clr  input  1  clears the conflict flags and the counter.
- q  output  WIDTH  registered channel state.
- q_n  output  WIDTH  registered complement; always equals ~q.
- q_rise  output  WIDTH  one-cycle pulse for each channel whose q went 0->1 this cycle.
- conflict  output  WIDTH  sticky per-channel flag; set when s[i]&r[i]&en was seen.
- conflict_cnt  output  CNT_W  saturating count of channel-conflict events.

Behaviour:
- Reset (rst=1 at a clock edge) forces:
  - q=INIT, q_n=~INIT
  - q_rise=0, conflict=0, conflict_cnt=0
- rst overrides en and conflict_clr. Asserting rst mid-operation discards all pending activity on that edge.
- Latency: an input sampled at edge N is reflected on q/q_n/q_rise after edge N. There is no combinational path from inputs to outputs.
- Per channel, when en=1:
  - s=1, r=0: q<=1.
  - s=0, r=1: q<=0.
  - s=0, r=0: hold.
  - s=1, r=1: apply CONFLICT_MODE. 0 holds, 1 gives q<=1, 2 gives q<=0, 3 gives q<=~q.
- When en=0, q holds, q_rise<=0, and no conflict is recorded, whatever s and r are.
- q_rise[i] <= (next q[i]==1) & (current q[i]==0). It is 0 on every cycle that does not follow a 0->1 transition, and 0 after reset even if INIT[i]=1.
- q_n is registered alongside q, not derived by an output inverter. Invariant: q_n == ~q on every cycle.
- Conflict event for channel i: en & s[i] & r[i].
- Conflict flags:
  - conflict[i] <= (conflict[i] & ~conflict_clr) | event[i].
  - If conflict_clr and a new event occur in the same cycle, the new event wins and the flag ends at 1.
- Conflict counter:
  - Each cycle, conflict_cnt adds popcount(event) (0..WIDTH).
  - If conflict_clr=1, the base is 0, so the result is popcount(event) of that cycle.
  - The sum saturates at 2^CNT_W-1 and never wraps. Once saturated, it stays there until conflict_clr or rst.
  - Adder width: CNT_W+1 bits internally. Compare against max before the register update.
- conflict_clr has no effect on q, q_n or q_rise.

Decomposition:
- Package sr_pkg:
  - mode constants SR_HOLD=0, SR_SET_DOM=1, SR_RST_DOM=2, SR_TOGGLE=3.
  - a 2-bit sr_mode_t typedef.
  - a popcount function used by the counter.
- Sub-module sr_cell handles one channel. It takes clk, rst, en, s, r, init_val and the mode parameter, and returns q, q_n, q_rise, event. The bank instantiates WIDTH cells in a generate loop.
- The top level holds the conflict flags, the popcount and the saturating counter.

Test Plan:
- Reset and basic set/reset, WIDTH=4, INIT=4'b0000:
  - Stimulus: rst for 2 cycles, then en=1, s=4'b0101, r=0.
  - Required: after the next edge q=0101, q_n=1010, q_rise=0101. One cycle later, with s=0, q_rise=0000.
  - Then r=4'b0001 gives q=0100.
- Conflict policies: run one instance per CONFLICT_MODE 0..3, each starting at q=4'b0011, then apply s=r=4'b1111 for one edge.
  - Required q: hold gives 0011, set-dom gives 1111, reset-dom gives 0000, toggle gives 1100.
  - In every mode, conflict=1111 and conflict_cnt=4.
- Enable gating: with en=0, s=1111, r=1010 for 3 cycles -> q unchanged, q_rise=0, conflict=0, conflict_cnt=0.
- Clear vs new event: conflict=0011 and cnt=5, then conflict_clr=1 in the same cycle as s=r=4'b0100 with en=1 -> conflict=0100, conflict_cnt=1.
- Saturation, CNT_W=4: hold s=r=4'b1111 with en=1 for 5 cycles -> cnt sequence 4, 8, 12, 15, 15 (no wrap). Then conflict_clr alone -> cnt=0.
- Reset mid-operation, INIT=4'b1001:
  - Setup: q=0110, conflict=1111, cnt=7.
  - Stimulus: assert rst together with s=1111 and conflict_clr=0.
  - Required: q=1001, q_n=0110, q_rise=0000, conflict=0, cnt=0.
